// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings, TX/RX state types and the oversample counter width helper.
package uart_pkg;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_OFF  = 2'b11;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
    function automatic int os_width(input int os);
        return $clog2(os);
    endfunction
endpackage

// File: rtl/uart_param_if.sv
// uart_param_if: host handshakes, frame configuration, serial pads and status of uart_param.
interface uart_param_if #(parameter int DATA_BITS = 8, parameter int DIV_W = 16);
    logic [DIV_W-1:0]     baud_div;
    logic [1:0]           parity_mode;
    logic                 two_stop;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;
    logic                 err_clr;
    logic                 tx_busy;
    logic                 rx_busy;
    modport slave (
        input  baud_div, parity_mode, two_stop, tx_data, tx_valid, rx, rx_ready, err_clr,
        output tx_ready, tx, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, tx_busy, rx_busy
    );
    modport master (
        output baud_div, parity_mode, two_stop, tx_data, tx_valid, rx, rx_ready, err_clr,
        input  tx_ready, tx, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, tx_busy, rx_busy
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: prescaler emitting one tick every i_div+1 cycles, zeroed by i_restart.
module uart_baud_gen #(parameter int DIV_W = 16) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;
    assign o_tick = !i_restart && (r_cnt == i_div);
    always_ff @(posedge clk)
        if (!rst_n || i_restart) r_cnt <= '0;
        else r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_param.sv
// uart_param: full-duplex UART with latched per-frame config and majority-vote RX.
// Define UART_PARITY_EN to honour parity_mode; otherwise frames carry no parity bit.
module uart_param import uart_pkg::*; #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input logic clk,
    input logic rst_n,
    uart_param_if.slave bus
);
    localparam int OW = os_width(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] S0 = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] S1 = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] S2 = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    tx_state_t r_tx_st, w_tx_nx;
    logic [DATA_BITS-1:0] r_tx_sh;
    logic [OW-1:0] r_tx_os;
    logic [BW-1:0] r_tx_bit;
    logic [DIV_W-1:0] r_tx_div;
    logic r_tx_par, r_tx_pen, r_tx_two;
    logic w_tx_go, w_tx_tick, w_tx_end, w_tx;
    assign w_tx_go  = (r_tx_st == TX_IDLE) && bus.tx_valid;
    assign w_tx_end = w_tx_tick && (r_tx_os == OS_LAST);
    uart_baud_gen #(.DIV_W(DIV_W)) u_tx_baud (
        .clk(clk), .rst_n(rst_n), .i_restart(w_tx_go), .i_div(r_tx_div), .o_tick(w_tx_tick)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_st  <= TX_IDLE;
            r_tx_sh  <= '0;
            r_tx_os  <= '0;
            r_tx_bit <= '0;
            r_tx_div <= '0;
            r_tx_par <= 1'b0;
            r_tx_pen <= 1'b0;
            r_tx_two <= 1'b0;
        end else begin
            r_tx_st <= w_tx_nx;
            if (w_tx_go) begin
                r_tx_sh  <= bus.tx_data;
                r_tx_par <= ^bus.tx_data ^ (bus.parity_mode == PAR_ODD);
                r_tx_pen <= PAR_EN && (bus.parity_mode == PAR_EVEN || bus.parity_mode == PAR_ODD);
                r_tx_two <= bus.two_stop;
                r_tx_div <= bus.baud_div;
                r_tx_os  <= '0;
                r_tx_bit <= '0;
            end else if (w_tx_tick) begin
                r_tx_os <= r_tx_os + 1'b1;
                if (w_tx_end && r_tx_st == TX_DATA) begin
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx_bit <= r_tx_bit + 1'b1;
                end
            end
        end
    end
    always_comb begin
        w_tx_nx = r_tx_st;
        w_tx    = 1'b1;
        case (r_tx_st)
            TX_IDLE:   if (bus.tx_valid) w_tx_nx = TX_START;
            TX_START:  begin w_tx = 1'b0; if (w_tx_end) w_tx_nx = TX_DATA; end
            TX_DATA:   begin
                w_tx = r_tx_sh[0];
                if (w_tx_end && r_tx_bit == LAST_BIT) w_tx_nx = r_tx_pen ? TX_PARITY : TX_STOP1;
            end
            TX_PARITY: begin w_tx = r_tx_par; if (w_tx_end) w_tx_nx = TX_STOP1; end
            TX_STOP1:  if (w_tx_end) w_tx_nx = r_tx_two ? TX_STOP2 : TX_IDLE;
            TX_STOP2:  if (w_tx_end) w_tx_nx = TX_IDLE;
            default:   w_tx_nx = TX_IDLE;
        endcase
    end
    assign bus.tx       = !rst_n || w_tx;
    assign bus.tx_ready = rst_n && (r_tx_st == TX_IDLE);
    assign bus.tx_busy  = (r_tx_st != TX_IDLE);
    rx_state_t r_rx_st, w_rx_nx;
    logic r_sync1, r_sync2;
    logic [DATA_BITS-1:0] r_rx_sh, r_rx_data;
    logic [OW-1:0] r_rx_os;
    logic [BW-1:0] r_rx_bit;
    logic [DIV_W-1:0] r_rx_div;
    logic [1:0] r_vote;
    logic r_rx_pen, r_rx_odd, r_rx_bad, r_rx_valid, r_ferr, r_perr, r_ovr;
    logic w_rx_go, w_rx_tick, w_rx_end, w_samp, w_vote, w_done, w_deliver, w_accept;
    assign w_rx_go   = (r_rx_st == RX_IDLE) && !r_sync2;
    assign w_rx_end  = w_rx_tick && (r_rx_os == OS_LAST);
    assign w_samp    = w_rx_tick && (r_rx_os == S2);
    assign w_vote    = (r_vote[1] & r_vote[0]) | (r_vote[1] & r_sync2) | (r_vote[0] & r_sync2);
    assign w_done    = (r_rx_st == RX_STOP) && w_samp;
    assign w_deliver = w_done && w_vote;
    assign w_accept  = !r_rx_valid || bus.rx_ready;
    uart_baud_gen #(.DIV_W(DIV_W)) u_rx_baud (
        .clk(clk), .rst_n(rst_n), .i_restart(w_rx_go), .i_div(r_rx_div), .o_tick(w_rx_tick)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_st    <= RX_IDLE;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_os    <= '0;
            r_rx_bit   <= '0;
            r_rx_div   <= '0;
            r_vote     <= '0;
            r_rx_pen   <= 1'b0;
            r_rx_odd   <= 1'b0;
            r_rx_bad   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
            r_rx_st <= w_rx_nx;
            if (w_rx_go) begin
                r_rx_os  <= '0;
                r_rx_bit <= '0;
                r_rx_pen <= PAR_EN && (bus.parity_mode == PAR_EVEN || bus.parity_mode == PAR_ODD);
                r_rx_odd <= (bus.parity_mode == PAR_ODD);
                r_rx_div <= bus.baud_div;
            end else if (w_rx_tick) begin
                r_rx_os <= r_rx_os + 1'b1;
                if (r_rx_os == S0 || r_rx_os == S1) r_vote <= {r_vote[0], r_sync2};
                if (w_samp && r_rx_st == RX_DATA) r_rx_sh <= {w_vote, r_rx_sh[DATA_BITS-1:1]};
                if (w_samp && r_rx_st == RX_PARITY) r_rx_bad <= w_vote ^ (^r_rx_sh) ^ r_rx_odd;
                if (w_rx_end && r_rx_st == RX_DATA) r_rx_bit <= r_rx_bit + 1'b1;
            end
            // A completing byte wins over a same-cycle read, and error sets win over err_clr
            r_rx_valid <= (w_deliver && w_accept) || (r_rx_valid && !bus.rx_ready);
            if (w_deliver && w_accept) r_rx_data <= r_rx_sh;
            r_ferr <= (w_done && !w_vote) || (r_ferr && !bus.err_clr);
            r_perr <= (w_deliver && r_rx_pen && r_rx_bad) || (r_perr && !bus.err_clr);
            r_ovr  <= (w_deliver && !w_accept) || (r_ovr && !bus.err_clr);
        end
    end
    always_comb begin
        w_rx_nx = r_rx_st;
        case (r_rx_st)
            RX_IDLE:   if (!r_sync2) w_rx_nx = RX_START;
            RX_START:  if (w_samp && w_vote) w_rx_nx = RX_IDLE;
                       else if (w_rx_end) w_rx_nx = RX_DATA;
            RX_DATA:   if (w_rx_end && r_rx_bit == LAST_BIT) w_rx_nx = r_rx_pen ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_end) w_rx_nx = RX_STOP;
            RX_STOP:   if (w_samp) w_rx_nx = w_vote ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (r_sync2) w_rx_nx = RX_IDLE;
            default:   w_rx_nx = RX_IDLE;
        endcase
    end
    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_frame_err  = r_ferr;
    assign bus.rx_parity_err = PAR_EN && r_perr;
    assign bus.rx_overrun    = r_ovr;
    assign bus.rx_busy       = (r_rx_st != RX_IDLE);
endmodule
